// File: rtl/objective.sv
// Error-generation stage closing the perceptron training loop: pairs each result with
// its target label, returns a scaled signed error and counts mispredictions.
module objective #(
    parameter int SHIFT = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        arg_stb,
    input  logic [7:0]  arg_dat,
    output logic        arg_rdy,
    input  logic        tgt_stb,
    input  logic [7:0]  tgt_dat,
    output logic        tgt_rdy,
    output logic        err_stb,
    output logic [15:0] err_dat,
    input  logic        err_rdy,
    output logic [15:0] cnt
);

    localparam int DATA_W = 8;
    localparam int ERR_W  = 16;
    localparam int CNT_W  = 16;

    typedef enum logic {
        COLLECT = 1'b0,
        SEND    = 1'b1
    } state_t;

    // The 9-bit difference is sign-extended before shifting; SHIFT<=7 keeps it in 16 bits.
    function automatic logic signed [ERR_W-1:0] scale_err(
        input logic [DATA_W-1:0] tgt,
        input logic [DATA_W-1:0] arg
    );
        logic signed [DATA_W:0]  diff;
        logic signed [ERR_W-1:0] ext;
        diff = $signed({1'b0, tgt}) - $signed({1'b0, arg});
        ext  = ERR_W'(diff);
        return ext <<< SHIFT;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    state_t                   state_q, state_d;
    logic                     have_arg_q, have_arg_d;
    logic                     have_tgt_q, have_tgt_d;
    logic [DATA_W-1:0]        arg_hold_q, arg_hold_d;
    logic [DATA_W-1:0]        tgt_hold_q, tgt_hold_d;
    logic signed [ERR_W-1:0]  err_q, err_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;

    logic                     arg_rdy_int, tgt_rdy_int, err_stb_int;
    logic                     arg_fire, tgt_fire;
    logic [DATA_W-1:0]        arg_val, tgt_val;

    // Handshake outputs come only from registered state, en and rst.
    always_comb begin
        arg_rdy_int = en & ~rst & (state_q == COLLECT) & ~have_arg_q;
        tgt_rdy_int = en & ~rst & (state_q == COLLECT) & ~have_tgt_q;
        err_stb_int = en & ~rst & (state_q == SEND);
        arg_fire    = arg_stb & arg_rdy_int;
        tgt_fire    = tgt_stb & tgt_rdy_int;
        arg_val     = arg_fire ? arg_dat : arg_hold_q;
        tgt_val     = tgt_fire ? tgt_dat : tgt_hold_q;
    end

    always_comb begin
        state_d    = state_q;
        have_arg_d = have_arg_q;
        have_tgt_d = have_tgt_q;
        arg_hold_d = arg_hold_q;
        tgt_hold_d = tgt_hold_q;
        err_d      = err_q;
        cnt_d      = cnt_q;

        case (state_q)
            COLLECT: begin
                if (arg_fire) begin
                    have_arg_d = 1'b1;
                    arg_hold_d = arg_dat;
                end
                if (tgt_fire) begin
                    have_tgt_d = 1'b1;
                    tgt_hold_d = tgt_dat;
                end
                // Completing capture: either operand may arrive last, or both together.
                if ((have_arg_q | arg_fire) & (have_tgt_q | tgt_fire) & (arg_fire | tgt_fire)) begin
                    err_d      = scale_err(tgt_val, arg_val);
                    if (tgt_val != arg_val) begin
                        cnt_d = sat_inc(cnt_q);
                    end
                    have_arg_d = 1'b0;
                    have_tgt_d = 1'b0;
                    state_d    = SEND;
                end
            end
            SEND: begin
                if (err_stb_int & err_rdy) begin
                    state_d = COLLECT;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= COLLECT;
            have_arg_q <= 1'b0;
            have_tgt_q <= 1'b0;
            err_q      <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            have_arg_q <= have_arg_d;
            have_tgt_q <= have_tgt_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
        end
    end

    // Operand holding registers are only meaningful while their flag is set.
    always_ff @(posedge clk) begin
        arg_hold_q <= arg_hold_d;
        tgt_hold_q <= tgt_hold_d;
    end

    assign arg_rdy = arg_rdy_int;
    assign tgt_rdy = tgt_rdy_int;
    assign err_stb = err_stb_int;
    assign err_dat = rst ? '0 : err_q;
    assign cnt     = rst ? '0 : cnt_q;

endmodule

// File: tb/tb_objective.sv
// Bench for objective: directed scenarios plus randomized pairs checked against an
// arithmetic model of the error and the saturating mismatch count.
module tb_objective;

    localparam int SHIFT = 7;

    logic        clk = 1'b0;
    logic        rst, en;
    logic        arg_stb, tgt_stb, err_rdy;
    logic [7:0]  arg_dat, tgt_dat;
    logic        arg_rdy, tgt_rdy, err_stb;
    logic [15:0] err_dat, cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int model_cnt = 0;

    always #5 clk = ~clk;

    objective #(.SHIFT(SHIFT)) dut (
        .clk(clk), .rst(rst), .en(en),
        .arg_stb(arg_stb), .arg_dat(arg_dat), .arg_rdy(arg_rdy),
        .tgt_stb(tgt_stb), .tgt_dat(tgt_dat), .tgt_rdy(tgt_rdy),
        .err_stb(err_stb), .err_dat(err_dat), .err_rdy(err_rdy),
        .cnt(cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Reference: plain integer difference times 2^SHIFT, truncated to 16 bits.
    function automatic logic [15:0] exp_err(input int a, input int t);
        int d;
        d = (t - a) * (1 << SHIFT);
        return d[15:0];
    endfunction

    function automatic void model_update(input int a, input int t);
        if (a != t && model_cnt < 65535) model_cnt++;
    endfunction

    // Expects err_stb now; holds err_rdy low for bp cycles, then completes the transfer.
    task automatic await_err(input logic [15:0] exp, input int bp);
        settle();
        chk("err_stb_rise", err_stb, 1'b1);
        chk("err_dat", err_dat, exp);
        chk("cnt", cnt, model_cnt[15:0]);
        for (int i = 0; i < bp; i++) begin
            err_rdy = 1'b0;
            tick();
            chk("bp_err_stb", err_stb, 1'b1);
            chk("bp_err_dat", err_dat, exp);
            chk("bp_rdy", {arg_rdy, tgt_rdy}, 2'b00);
        end
        err_rdy = 1'b1;
        tick();
        err_rdy = 1'b0;
        settle();
        chk("post_send_stb", err_stb, 1'b0);
        chk("post_send_rdy", {arg_rdy, tgt_rdy}, 2'b11);
    endtask

    // mode 0: both operands together; 1: arg then tgt; 2: tgt then arg.
    task automatic do_pair(input logic [7:0] a, input logic [7:0] t, input int mode,
                           input int gap, input int bp);
        if (mode == 0) begin
            arg_stb = 1'b1; arg_dat = a;
            tgt_stb = 1'b1; tgt_dat = t;
            settle();
            chk("both_rdy", {arg_rdy, tgt_rdy}, 2'b11);
            tick();
            arg_stb = 1'b0; tgt_stb = 1'b0;
        end else begin
            if (mode == 1) begin
                arg_stb = 1'b1; arg_dat = a;
            end else begin
                tgt_stb = 1'b1; tgt_dat = t;
            end
            settle();
            chk("first_rdy", {arg_rdy, tgt_rdy}, 2'b11);
            tick();
            arg_stb = 1'b0; tgt_stb = 1'b0;
            arg_dat = 8'($urandom); tgt_dat = 8'($urandom);
            for (int i = 0; i < gap; i++) begin
                settle();
                chk("hold_rdy", {arg_rdy, tgt_rdy}, (mode == 1) ? 2'b01 : 2'b10);
                chk("hold_stb", err_stb, 1'b0);
                tick();
            end
            if (mode == 1) begin
                tgt_stb = 1'b1; tgt_dat = t;
            end else begin
                arg_stb = 1'b1; arg_dat = a;
            end
            settle();
            chk("second_rdy", {arg_rdy, tgt_rdy}, (mode == 1) ? 2'b01 : 2'b10);
            tick();
            arg_stb = 1'b0; tgt_stb = 1'b0;
            arg_dat = 8'($urandom); tgt_dat = 8'($urandom);
        end
        model_update(int'(a), int'(t));
        await_err(exp_err(int'(a), int'(t)), bp);
    endtask

    initial begin
        logic [7:0] ra, rt;
        logic [15:0] held;
        rst = 1'b1; en = 1'b1;
        arg_stb = 1'b0; tgt_stb = 1'b0; err_rdy = 1'b0;
        arg_dat = 8'h00; tgt_dat = 8'h00;

        // Reset state
        tick(); tick();
        chk("rst_err_stb", err_stb, 1'b0);
        chk("rst_cnt", cnt, 16'h0000);
        chk("rst_err_dat", err_dat, 16'h0000);
        rst = 1'b0;
        settle();
        chk("post_rst_rdy", {arg_rdy, tgt_rdy}, 2'b11);
        chk("post_rst_cnt", cnt, 16'h0000);
        chk("post_rst_err", err_dat, 16'h0000);

        // Same-cycle capture, maximum positive error
        do_pair(8'h00, 8'hFF, 0, 0, 0);
        chk("max_pos_cnt", cnt, 16'h0001);

        // Arg first, target three cycles later, maximum negative error
        do_pair(8'hFF, 8'h00, 1, 2, 0);
        chk("max_neg_cnt", cnt, 16'h0002);

        // Zero difference still produces an error; back-pressure for 5 cycles
        do_pair(8'h80, 8'h80, 0, 0, 5);
        chk("zero_cnt", cnt, 16'h0002);

        // en low while holding only arg: nothing captured, then identical completion
        arg_stb = 1'b1; arg_dat = 8'h10;
        tick();
        arg_stb = 1'b0;
        en = 1'b0;
        tgt_stb = 1'b1; tgt_dat = 8'h55;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("en_lo_collect", {arg_rdy, tgt_rdy, err_stb}, 3'b000);
            tick();
        end
        en = 1'b1; tgt_dat = 8'h30;
        settle();
        chk("en_resume_rdy", {arg_rdy, tgt_rdy}, 2'b01);
        tick();
        tgt_stb = 1'b0;
        model_update(8'h10, 8'h30);
        settle();
        chk("en_resume_err", err_dat, 16'h1000);
        held = err_dat;

        // en low while in SEND, with the consumer ready
        en = 1'b0; err_rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("en_lo_send", {arg_rdy, tgt_rdy, err_stb}, 3'b000);
            chk("en_lo_send_dat", err_dat, held);
            tick();
        end
        err_rdy = 1'b0; en = 1'b1;
        await_err(16'h1000, 1);
        chk("en_cnt", cnt, model_cnt[15:0]);

        // Randomized pairs with random ordering, gaps, back-pressure and idle en-low cycles
        for (int n = 0; n < 60; n++) begin
            ra = 8'($urandom);
            rt = ($urandom_range(0, 3) == 0) ? ra : 8'($urandom);
            do_pair(ra, rt, $urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) begin
                en = 1'b0;
                settle();
                chk("rand_en_lo", {arg_rdy, tgt_rdy, err_stb}, 3'b000);
                tick();
                en = 1'b1;
            end
        end

        // Saturation: preload the counter one short of full scale
        force dut.cnt_q = 16'hFFFE;
        tick();
        release dut.cnt_q;
        tick();
        settle();
        model_cnt = 32'h0000FFFE;
        chk("preload_cnt", cnt, 16'hFFFE);
        do_pair(8'h01, 8'h02, 0, 0, 0);
        chk("sat_cnt_1", cnt, 16'hFFFF);
        do_pair(8'h40, 8'h03, 2, 1, 0);
        chk("sat_cnt_2", cnt, 16'hFFFF);

        // Reset with arg held and a simultaneous target offer
        arg_stb = 1'b1; arg_dat = 8'h11;
        tick();
        arg_stb = 1'b0;
        rst = 1'b1; tgt_stb = 1'b1; tgt_dat = 8'h22;
        settle();
        chk("rst_mid_stb", err_stb, 1'b0);
        chk("rst_mid_cnt", cnt, 16'h0000);
        chk("rst_mid_rdy", {arg_rdy, tgt_rdy}, 2'b00);
        tick();
        rst = 1'b0; tgt_stb = 1'b0;
        settle();
        model_cnt = 0;
        chk("rst_flags", {arg_rdy, tgt_rdy, err_stb}, 3'b110);
        chk("rst_cnt_after", cnt, 16'h0000);
        do_pair(8'h05, 8'h07, 2, 1, 0);
        chk("rst_fresh_cnt", cnt, 16'h0001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
